// File: rtl/mem_access_stage.sv
// mem_access_stage: turns EX/MEM loads/stores into bus request/grant/response transactions, freezing the pipeline while outstanding
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              M_mem_read_i,
  input  logic              M_mem_write_i,
  input  logic [1:0]        M_size_i,
  input  logic              M_unsigned_i,
  input  logic [31:0]       M_alu_res_i,
  input  logic [31:0]       M_store_data_i,
  input  logic [4:0]        M_rd_i,
  input  logic              M_w_reg_ena_i,
  input  logic              M_wb_sel_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  output logic [31:0]       W_MEM_mem_data_o,
  output logic [31:0]       W_MEM_alu_res_o,
  output logic [4:0]        W_MEM_rd_o,
  output logic              W_MEM_wb_sel_o,
  output logic              W_MEM_w_reg_ena_o,
  output logic              mem_stall_o,
  output logic              addr_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d, gnt_next;
  logic kill_q, kill_d, kill, op, word, half, mis, idle_go;
  logic [31:0] rdata_q, rdata_d, lane, load_val;
  always_comb begin
    op = (M_mem_read_i | M_mem_write_i) & ~flush_i;
    word = M_size_i[1];
    half = M_size_i == 2'b01;
    mis = (half & M_alu_res_i[0]) | (word & |M_alu_res_i[1:0]);
    idle_go = rst & (state_q == IDLE) & op & ~mis;
    addr_err_o = rst & (state_q == IDLE) & op & mis;
    bus_req_o = idle_go | (rst & (state_q == REQ) & ~flush_i);
    bus_we_o = bus_req_o & M_mem_write_i;
    mem_stall_o = idle_go | (rst & ((state_q == REQ) | (state_q == WAIT)));
    bus_addr_o = {M_alu_res_i[ADDR_W-1:2], 2'b00};
    bus_be_o = word ? 4'hF : (half ? 4'b0011 : 4'b0001) << M_alu_res_i[1:0];
    bus_wdata_o = word ? M_store_data_i : half ? {2{M_store_data_i[15:0]}} : {4{M_store_data_i[7:0]}};
    lane = bus_rdata_i >> {M_alu_res_i[1:0], 3'b000};
    load_val = word ? lane
             : half ? {{16{~M_unsigned_i & lane[15]}}, lane[15:0]}
             : {{24{~M_unsigned_i & lane[7]}}, lane[7:0]};
    W_MEM_mem_data_o = rdata_q;
    W_MEM_alu_res_o = M_alu_res_i;
    W_MEM_rd_o = M_rd_i;
    W_MEM_wb_sel_o = M_wb_sel_i;
    W_MEM_w_reg_ena_o = M_w_reg_ena_i & ~addr_err_o;
    kill = kill_q | flush_i;
    gnt_next = M_mem_write_i ? DONE : WAIT;
    state_d = state_q;
    kill_d = kill_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: state_d = idle_go ? (bus_gnt_i ? gnt_next : REQ) : IDLE;
      REQ:  state_d = flush_i ? IDLE : bus_gnt_i ? gnt_next : REQ;
      WAIT: begin
        kill_d = bus_rvalid_i ? 1'b0 : kill;
        rdata_d = (bus_rvalid_i & ~kill) ? load_val : rdata_q;
        state_d = bus_rvalid_i ? (kill ? IDLE : DONE) : WAIT;
      end
      DONE: state_d = hold_i ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      kill_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q <= kill_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized and directed self-checking bench for mem_access_stage against a byte-level reference model
module tb_mem_access_stage;
  logic clk = 0, rst = 0;
  logic M_mem_read_i = 0, M_mem_write_i = 0, M_unsigned_i = 0, M_w_reg_ena_i = 0, M_wb_sel_i = 0;
  logic [1:0] M_size_i = 0;
  logic [31:0] M_alu_res_i = 0, M_store_data_i = 0, bus_rdata_i = 0;
  logic [4:0] M_rd_i = 0;
  logic flush_i = 0, hold_i = 0, bus_gnt_i = 0, bus_rvalid_i = 0;
  logic bus_req_o, bus_we_o, W_MEM_wb_sel_o, W_MEM_w_reg_ena_o, mem_stall_o, addr_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, W_MEM_mem_data_o, W_MEM_alu_res_o;
  logic [3:0] bus_be_o;
  logic [4:0] W_MEM_rd_o;
  int checks = 0, failures = 0;
  int obs_stalls, obs_reqs;
  logic obs_stable, obs_timeout, obs_we, obs_err, obs_wen;
  logic [3:0] obs_be;
  logic [31:0] obs_wdata, obs_addr, obs_data;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .M_mem_read_i(M_mem_read_i), .M_mem_write_i(M_mem_write_i), .M_size_i(M_size_i),
    .M_unsigned_i(M_unsigned_i), .M_alu_res_i(M_alu_res_i), .M_store_data_i(M_store_data_i),
    .M_rd_i(M_rd_i), .M_w_reg_ena_i(M_w_reg_ena_i), .M_wb_sel_i(M_wb_sel_i),
    .flush_i(flush_i), .hold_i(hold_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .W_MEM_mem_data_o(W_MEM_mem_data_o), .W_MEM_alu_res_o(W_MEM_alu_res_o), .W_MEM_rd_o(W_MEM_rd_o),
    .W_MEM_wb_sel_o(W_MEM_wb_sel_o), .W_MEM_w_reg_ena_o(W_MEM_w_reg_ena_o),
    .mem_stall_o(mem_stall_o), .addr_err_o(addr_err_o)
  );

  always #5 clk = ~clk;

  function automatic int nb(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    int m;
    m = ((1 << nb(sz)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (nb(sz) == 1) return {24'd0, d[7:0]} * 32'h01010101;
    if (nb(sz) == 2) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] r);
    int n;
    logic [31:0] v, mask;
    n = nb(sz);
    v = r >> (8 * (a % 4));
    mask = n == 4 ? 32'hFFFFFFFF : (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_txn(input logic ld, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] d, input int gd, input int rvd, input logic [31:0] rdat);
    int waitc;
    logic granted;
    @(negedge clk);
    M_mem_read_i = ld; M_mem_write_i = !ld; M_size_i = sz; M_unsigned_i = uns;
    M_alu_res_i = a; M_store_data_i = d;
    obs_stalls = 0; obs_reqs = 0; obs_stable = 1; obs_timeout = 1; waitc = 0; granted = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      bus_gnt_i = 0; bus_rvalid_i = 0;
      #1;
      if (!mem_stall_o) begin
        obs_timeout = 0;
        break;
      end
      obs_stalls++;
      if (bus_req_o) begin
        if (obs_reqs == 0) begin
          obs_be = bus_be_o; obs_wdata = bus_wdata_o; obs_addr = bus_addr_o; obs_we = bus_we_o;
        end else if (bus_be_o !== obs_be || bus_wdata_o !== obs_wdata || bus_addr_o !== obs_addr || bus_req_o !== 1'b1) obs_stable = 0;
        bus_gnt_i = (obs_reqs == gd);
        obs_reqs++;
        if (bus_gnt_i) granted = 1;
      end else if (granted) begin
        waitc++;
        if (waitc == rvd) begin
          bus_rvalid_i = 1;
          bus_rdata_i = rdat;
        end
      end
    end
    obs_data = W_MEM_mem_data_o; obs_err = addr_err_o; obs_wen = W_MEM_w_reg_ena_o;
    if (obs_timeout) begin
      checks++; failures++;
      $display("FAIL txn_timeout addr=%h stall never released", a);
    end
    M_mem_read_i = 0; M_mem_write_i = 0; bus_gnt_i = 0; bus_rvalid_i = 0;
  endtask

  task automatic test_reset;
    rst = 0; M_mem_read_i = 1; M_size_i = 2; M_alu_res_i = 32'h100;
    #13;
    checks++; if (bus_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus_req_o); end
    checks++; if (mem_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", mem_stall_o); end
    checks++; if (addr_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", addr_err_o); end
    checks++; if (W_MEM_mem_data_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", W_MEM_mem_data_o); end
    @(negedge clk);
    M_mem_read_i = 0; rst = 1;
  endtask

  task automatic test_lw;
    do_txn(1, 2'd2, 0, 32'h100, 0, 0, 1, 32'hDEADBEEF);
    checks++; if (obs_be !== 4'hF) begin failures++; $display("FAIL lw_be got=%h exp=f", obs_be); end
    checks++; if (obs_stalls !== 2) begin failures++; $display("FAIL lw_stalls got=%0d exp=2", obs_stalls); end
    checks++; if (obs_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", obs_data); end
    checks++; if (obs_addr !== 32'h100 || obs_we !== 1'b0) begin failures++; $display("FAIL lw_addr_we got=%h/%b exp=100/0", obs_addr, obs_we); end
  endtask

  task automatic test_lb;
    do_txn(1, 2'd0, 0, 32'h103, 0, 0, 1, 32'h80FFFFFF);
    checks++; if (obs_data !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_signed got=%h exp=ffffff80", obs_data); end
    checks++; if (obs_be !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", obs_be); end
    do_txn(1, 2'd0, 1, 32'h103, 0, 0, 1, 32'h80FFFFFF);
    checks++; if (obs_data !== 32'h00000080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", obs_data); end
  endtask

  task automatic test_sh_wait_gnt;
    do_txn(0, 2'd1, 0, 32'h202, 32'h1234ABCD, 3, 1, 0);
    checks++; if (obs_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", obs_be); end
    checks++; if (obs_wdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", obs_wdata); end
    checks++; if (obs_stable !== 1'b1 || obs_reqs !== 4) begin failures++; $display("FAIL sh_stable got=%b/%0d exp=1/4", obs_stable, obs_reqs); end
    checks++; if (obs_stalls !== 4) begin failures++; $display("FAIL sh_stalls got=%0d exp=4", obs_stalls); end
    checks++; if (obs_we !== 1'b1 || obs_addr !== 32'h200) begin failures++; $display("FAIL sh_we_addr got=%b/%h exp=1/200", obs_we, obs_addr); end
  endtask

  task automatic test_misaligned;
    @(negedge clk);
    M_mem_read_i = 1; M_size_i = 2; M_alu_res_i = 32'h101; M_w_reg_ena_i = 1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (addr_err_o !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", addr_err_o); end
      checks++; if (W_MEM_w_reg_ena_o !== 1'b0) begin failures++; $display("FAIL mis_wen got=%b exp=0", W_MEM_w_reg_ena_o); end
      checks++; if (bus_req_o !== 1'b0 || mem_stall_o !== 1'b0) begin failures++; $display("FAIL mis_req_stall got=%b/%b exp=0/0", bus_req_o, mem_stall_o); end
    end
    M_mem_read_i = 0;
  endtask

  task automatic test_flush_req;
    @(negedge clk);
    M_mem_read_i = 1; M_size_i = 2; M_alu_res_i = 32'h104;
    @(negedge clk); #1;
    checks++; if (bus_req_o !== 1'b1 || mem_stall_o !== 1'b1) begin failures++; $display("FAIL fr_req_held got=%b/%b exp=1/1", bus_req_o, mem_stall_o); end
    flush_i = 1;
    @(negedge clk);
    flush_i = 0; M_mem_read_i = 0;
    #1;
    checks++; if (bus_req_o !== 1'b0 || mem_stall_o !== 1'b0) begin failures++; $display("FAIL fr_dropped got=%b/%b exp=0/0", bus_req_o, mem_stall_o); end
  endtask

  task automatic test_flush_wait;
    do_txn(1, 2'd2, 0, 32'h108, 0, 0, 1, 32'h13572468);
    checks++; if (obs_data !== 32'h13572468) begin failures++; $display("FAIL fw_pre got=%h exp=13572468", obs_data); end
    @(negedge clk);
    M_mem_read_i = 1; M_size_i = 2; M_alu_res_i = 32'h10C;
    #1 bus_gnt_i = 1;
    @(negedge clk);
    bus_gnt_i = 0; flush_i = 1;
    #1;
    checks++; if (mem_stall_o !== 1'b1 || bus_req_o !== 1'b0) begin failures++; $display("FAIL fw_wait got=%b/%b exp=1/0", mem_stall_o, bus_req_o); end
    @(negedge clk);
    flush_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h55;
    @(negedge clk);
    bus_rvalid_i = 0;
    #1;
    checks++; if (W_MEM_mem_data_o !== 32'h13572468) begin failures++; $display("FAIL fw_discard got=%h exp=13572468", W_MEM_mem_data_o); end
    checks++; if (bus_req_o !== 1'b1) begin failures++; $display("FAIL fw_idle_not_done got=%b exp=1", bus_req_o); end
    flush_i = 1;
    @(negedge clk);
    flush_i = 0; M_mem_read_i = 0;
    #1;
    checks++; if (mem_stall_o !== 1'b0 || bus_req_o !== 1'b0) begin failures++; $display("FAIL fw_quiet got=%b/%b exp=0/0", mem_stall_o, bus_req_o); end
  endtask

  task automatic test_reset_wait;
    @(negedge clk);
    M_mem_read_i = 1; M_size_i = 2; M_alu_res_i = 32'h110;
    #1 bus_gnt_i = 1;
    @(negedge clk);
    bus_gnt_i = 0;
    #1;
    checks++; if (mem_stall_o !== 1'b1) begin failures++; $display("FAIL rw_in_wait got=%b exp=1", mem_stall_o); end
    #2 rst = 0;
    #1;
    checks++; if (mem_stall_o !== 1'b0 || bus_req_o !== 1'b0 || addr_err_o !== 1'b0) begin failures++; $display("FAIL rw_outputs got=%b/%b/%b exp=0/0/0", mem_stall_o, bus_req_o, addr_err_o); end
    checks++; if (W_MEM_mem_data_o !== 32'h0) begin failures++; $display("FAIL rw_data got=%h exp=0", W_MEM_mem_data_o); end
    @(negedge clk);
    M_mem_read_i = 0; rst = 1;
    do_txn(1, 2'd1, 1, 32'h112, 0, 0, 2, 32'hF00DCAFE);
    checks++; if (obs_data !== 32'h0000F00D || obs_stalls !== 3) begin failures++; $display("FAIL rw_after got=%h/%0d exp=0000f00d/3", obs_data, obs_stalls); end
  endtask

  task automatic test_hold_done;
    @(negedge clk);
    M_mem_write_i = 1; M_size_i = 2; M_alu_res_i = 32'h300; M_store_data_i = 32'hCAFEF00D;
    #1 bus_gnt_i = 1;
    @(negedge clk);
    bus_gnt_i = 0; hold_i = 1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (bus_req_o !== 1'b0 || mem_stall_o !== 1'b0) begin failures++; $display("FAIL hold_done got=%b/%b exp=0/0", bus_req_o, mem_stall_o); end
    end
    hold_i = 0;
    @(negedge clk); #1;
    checks++; if (bus_req_o !== 1'b1) begin failures++; $display("FAIL hold_release got=%b exp=1", bus_req_o); end
    M_mem_write_i = 0;
  endtask

  task automatic test_random;
    logic ld, uns, mis, wen;
    logic [1:0] sz;
    logic [31:0] a, d, r;
    logic [4:0] rd;
    int gd, rvd, n, exp_st;
    for (int i = 0; i < 30; i++) begin
      ld = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
      n = nb(sz);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % n);
      mis = (a % n) != 0;
      d = $urandom; r = $urandom; rd = 5'($urandom);
      gd = $urandom_range(0, 3); rvd = $urandom_range(1, 3);
      wen = 1'($urandom_range(0, 1));
      M_rd_i = rd; M_w_reg_ena_i = wen; M_wb_sel_i = ~wen;
      do_txn(ld, sz, uns, a, d, gd, rvd, r);
      exp_st = mis ? 0 : 1 + gd + (ld ? rvd : 0);
      checks++; if (obs_err !== mis) begin failures++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, obs_err, mis); end
      checks++; if (obs_stalls !== exp_st) begin failures++; $display("FAIL rnd_stalls i=%0d got=%0d exp=%0d", i, obs_stalls, exp_st); end
      checks++; if (obs_wen !== (wen & !mis)) begin failures++; $display("FAIL rnd_wen i=%0d got=%b exp=%b", i, obs_wen, wen & !mis); end
      checks++; if (W_MEM_alu_res_o !== a || W_MEM_rd_o !== rd || W_MEM_wb_sel_o !== ~wen) begin failures++; $display("FAIL rnd_pass i=%0d got=%h/%h/%b exp=%h/%h/%b", i, W_MEM_alu_res_o, W_MEM_rd_o, W_MEM_wb_sel_o, a, rd, ~wen); end
      if (!mis) begin
        checks++; if (obs_be !== exp_be(sz, a)) begin failures++; $display("FAIL rnd_be i=%0d got=%b exp=%b", i, obs_be, exp_be(sz, a)); end
        checks++; if (obs_wdata !== exp_wdata(sz, d)) begin failures++; $display("FAIL rnd_wdata i=%0d got=%h exp=%h", i, obs_wdata, exp_wdata(sz, d)); end
        checks++; if (obs_we !== !ld || obs_addr !== (a & 32'hFFFFFFFC) || obs_stable !== 1'b1) begin failures++; $display("FAIL rnd_req i=%0d got=%b/%h/%b exp=%b/%h/1", i, obs_we, obs_addr, obs_stable, !ld, a & 32'hFFFFFFFC); end
      end
      if (ld && !mis) begin
        checks++; if (obs_data !== exp_load(sz, uns, a, r)) begin failures++; $display("FAIL rnd_load i=%0d got=%h exp=%h", i, obs_data, exp_load(sz, uns, a, r)); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_lb;
    test_sh_wait_gnt;
    test_misaligned;
    test_flush_req;
    test_flush_wait;
    test_reset_wait;
    test_hold_done;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register. It turns a load/store from EX/MEM into a request/grant/response transaction on the data bus. Load data is aligned and sign/zero-extended before it goes downstream. While a transaction is outstanding the stage freezes the pipeline, and it flags misaligned accesses instead of issuing them.

## Interface
- `ADDR_W`, default 32: data-bus address width. Data width is fixed at 32.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `M_mem_read_i` in 1: the instruction is a load.
- `M_mem_write_i` in 1: the instruction is a store.
- `M_size_i` in 2: access size. 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `M_unsigned_i` in 1: zero-extend load data (1) or sign-extend it (0).
- `M_alu_res_i` in 32: effective address, also passed through as the result.
- `M_store_data_i` in 32: store source, taken from bits [7:0], [15:0] or [31:0].
- `M_rd_i` in 5: destination register, passed through.
- `M_w_reg_ena_i` in 1: register-write enable, passed through.
- `M_wb_sel_i` in 1: writeback-source select, passed through.
- `flush_i` in 1: kill the current instruction.
- `hold_i` in 1: external freeze from the hazard unit.
- `bus_req_o` out 1: request valid.
- `bus_we_o` out 1: request is a write.
- `bus_addr_o` out ADDR_W: word-aligned address, `{alu_res[ADDR_W-1:2],2'b00}`.
- `bus_be_o` out 4: byte enables.
- `bus_wdata_o` out 32: write data, replicated across the lanes.
- `bus_gnt_i` in 1: request accepted this cycle.
- `bus_rvalid_i` in 1: read data valid.
- `bus_rdata_i` in 32: read data.
- `W_MEM_mem_data_o` out 32: aligned, extended load data.
- `W_MEM_alu_res_o` out 32: pass-through of `M_alu_res_i`.
- `W_MEM_rd_o` out 5: pass-through of `M_rd_i`.
- `W_MEM_wb_sel_o` out 1: pass-through of `M_wb_sel_i`.
- `W_MEM_w_reg_ena_o` out 1: pass-through of `M_w_reg_ena_i`, forced to 0 on `addr_err_o`.
- `mem_stall_o` out 1: active-high freeze for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- `addr_err_o` out 1: misaligned access detected.

## Operation
- **Memory op:** `op = (M_mem_read_i | M_mem_write_i) & ~flush_i`.
- **Misalignment:** a half access with `addr[0] = 1`, or a word access with `addr[1:0] != 0`. When this holds in IDLE:
  - no bus request is issued;
  - `addr_err_o = 1` combinationally;
  - `W_MEM_w_reg_ena_o = 0`;
  - no stall; the state stays IDLE.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`;
  - half: `4'b0011 << addr[1:0]`;
  - word: `4'b1111`.
- **Write data:**
  - byte: `{4{d[7:0]}}`;
  - half: `{2{d[15:0]}}`;
  - word: `d`.
- **Load data:** lane select uses `addr[1:0]`, then the value is extended per `M_unsigned_i`. It is registered into `rdata_q` on the cycle with `bus_rvalid_i`. `W_MEM_mem_data_o = rdata_q`.
- **FSM, 4 states:**
  - **IDLE**
    - Aligned op: `bus_req_o = 1` and `mem_stall_o = 1`.
    - On `bus_gnt_i`: a store goes to DONE, a load goes to WAIT.
    - Without `bus_gnt_i`: go to REQ.
    - No op: stay in IDLE, `mem_stall_o = 0`.
  - **REQ**
    - `bus_req_o = 1` with unchanged address, be and wdata (the pipeline is frozen), and `mem_stall_o = 1`.
    - Grant handling is the same as in IDLE.
    - `flush_i` before grant drops the request and returns to IDLE.
  - **WAIT**
    - `bus_req_o = 0`, `mem_stall_o = 1`.
    - On `bus_rvalid_i`: capture into `rdata_q` and go to DONE.
    - `flush_i` sets a sticky `kill_q`. On `bus_rvalid_i` the data is discarded and the FSM returns to IDLE.
  - **DONE**
    - `mem_stall_o = 0`, so MEM/WB latches the result.
    - Go to IDLE unless `hold_i = 1`, in which case stay in DONE.
    - This prevents re-issue of the same op.
- `bus_we_o = M_mem_write_i` whenever `bus_req_o = 1`; otherwise 0.
- Pass-through outputs are purely combinational.

## Timing
- **Reset (`rst = 0`, asynchronous):**
  - state IDLE, `rdata_q = 0`, `kill_q = 0`;
  - `bus_req_o = 0`, `mem_stall_o = 0`, `addr_err_o = 0`.
  - Reset during REQ or WAIT abandons the transaction with no completion; the bus is reset by the same `rst`.
- **Store, immediate grant:** one stall cycle (IDLE), then DONE. The result reaches MEM/WB at the end of the DONE cycle.
- **Load, immediate grant, rvalid N cycles after the grant (N ≥ 1):** stall cycles = 1 + N, then DONE.
- **Each REQ cycle without a grant** adds one stall cycle.
- **`bus_gnt_i` and `bus_rvalid_i` in the same cycle are not allowed:** rvalid is at least one cycle after gnt. In IDLE or REQ, rvalid is ignored.
- **`hold_i` during REQ or WAIT:** no effect on the FSM.
- **`flush_i` in DONE:** ignored, because the op is already committed.

## Test plan
- **Aligned `lw`, addr 0x100:**
  - gnt in the first cycle, rdata 0xDEADBEEF one cycle later;
  - expected: `bus_be_o = 4'hF`, stall exactly 2 cycles, then `W_MEM_mem_data_o = 0xDEADBEEF` in DONE.
- **`lb` at addr 0x103, signed, rdata 0x80FFFFFF:** expected `W_MEM_mem_data_o = 0xFFFFFF80`, `bus_be_o = 4'b1000`. Repeat with `M_unsigned_i = 1`: expected 0x00000080.
- **`sh` at addr 0x202, data 0x1234ABCD, gnt held low 3 cycles:**
  - `bus_req_o`, `bus_addr_o` and `bus_wdata_o` stay stable for 4 cycles;
  - `bus_be_o = 4'b1100`, `bus_wdata_o = 0xABCDABCD`;
  - stall lasts 4 cycles.
- **`lw` at addr 0x101:**
  - `addr_err_o = 1`, `W_MEM_w_reg_ena_o = 0`;
  - `bus_req_o` never asserts, `mem_stall_o` stays 0.
- **Flush cases:**
  - `flush_i` in REQ: the request drops next cycle and the FSM returns to IDLE.
  - `flush_i` in WAIT: rvalid with 0x55 is discarded, `rdata_q` is unchanged, and the FSM returns to IDLE without DONE.
- **Reset and hold:**
  - asynchronous `rst` low mid-WAIT clears the outputs immediately;
  - `hold_i` high in DONE keeps the FSM in DONE with no second request.
